// File: rtl/pixel_tx_scheduler.sv
// Pixel packet launch scheduler: arbitrates held miner results against periodic heartbeats and
// launches one generator packet per request during vertical blanking, with ack/frame timeouts.
module pixel_tx_scheduler #(
   parameter int unsigned DLEN          = 32'h002b,
   parameter int unsigned activeVideo_h = 640,
   parameter int unsigned activeVideo_v = 480,
   parameter int unsigned HB_PERIOD     = 60,
   parameter int unsigned MAX_RES_RUN   = 4,
   parameter int unsigned ACK_TIMEOUT   = 8,
   parameter int unsigned FRAME_TIMEOUT = 2
) (
   input  logic                tx_pixel_clk,
   input  logic                rst_n,
   input  logic [9:0]          x,
   input  logic [9:0]          y,
   input  logic                result_valid,
   input  logic [DLEN*8-1:0]   result_data,
   output logic                result_ready,
   input  logic                gen_busy,
   output logic [DLEN*8-1:0]   gen_data,
   output logic                gen_write_enable,
   output logic                gen_data_available,
   output logic [15:0]         frames_sent,
   output logic                err_timeout
);

   localparam int unsigned DW = DLEN * 8;

   localparam logic [9:0]  VActive = 10'(activeVideo_v);
   localparam logic [15:0] HbLast  = 16'(HB_PERIOD - 1);
   localparam logic [15:0] MaxRun  = 16'(MAX_RES_RUN);
   localparam logic [15:0] AckLast = 16'(ACK_TIMEOUT - 1);
   localparam logic [15:0] FtoLast = 16'(FRAME_TIMEOUT - 1);

   // Blanking must be reachable on a 10-bit line coordinate.
   if (HB_PERIOD < 1 || ACK_TIMEOUT < 1 || FRAME_TIMEOUT < 1) begin : g_bad_timing
      $error("pixel_tx_scheduler: HB_PERIOD, ACK_TIMEOUT and FRAME_TIMEOUT must be >= 1");
   end
   if (activeVideo_h < 1 || activeVideo_h > 1024 || activeVideo_v > 1022) begin : g_bad_video
      $error("pixel_tx_scheduler: active video size does not fit 10-bit coordinates");
   end

   typedef enum logic [2:0] {StIdle, StLaunch, StWaitAck, StActive, StDone} state_e;

   state_e          state_q, state_d;
   logic            frame_start_q, frame_start_d;
   logic            hold_full_q, hold_full_d;
   logic [DW-1:0]   hold_data_q, hold_data_d;
   logic            hb_pending_q, hb_pending_d;
   logic [15:0]     hb_cnt_q, hb_cnt_d;
   logic [15:0]     res_run_q, res_run_d;
   logic [15:0]     ack_cnt_q, ack_cnt_d;
   logic [15:0]     fto_cnt_q, fto_cnt_d;
   logic            cur_hb_q, cur_hb_d;
   logic [DW-1:0]   gen_data_q, gen_data_d;
   logic [15:0]     frames_sent_q, frames_sent_d;
   logic            err_q, err_d;

   logic blank;
   logic sel_result, sel_hb;
   logic launch_res, launch_hb;
   logic clr_served, hb_set;

   assign blank      = (y > VActive);
   assign sel_result = hold_full_q && (!hb_pending_q || (res_run_q < MaxRun));
   assign sel_hb     = !sel_result && hb_pending_q;

   always_comb begin
      state_d       = state_q;
      frame_start_d = (x == 10'd0) && (y == 10'd0);
      hold_full_d   = hold_full_q;
      hold_data_d   = hold_data_q;
      hb_pending_d  = hb_pending_q;
      hb_cnt_d      = hb_cnt_q;
      res_run_d     = res_run_q;
      ack_cnt_d     = ack_cnt_q;
      fto_cnt_d     = fto_cnt_q;
      cur_hb_d      = cur_hb_q;
      gen_data_d    = gen_data_q;
      frames_sent_d = frames_sent_q;
      err_d         = err_q;
      launch_res    = 1'b0;
      launch_hb     = 1'b0;
      clr_served    = 1'b0;
      hb_set        = 1'b0;

      if (result_valid && !hold_full_q) begin
         hold_full_d = 1'b1;
         hold_data_d = result_data;
      end

      if (frame_start_q) begin
         if (hb_cnt_q == HbLast) begin
            hb_cnt_d = 16'd0;
            hb_set   = 1'b1;
         end else begin
            hb_cnt_d = hb_cnt_q + 16'd1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (blank && !gen_busy && (sel_result || sel_hb)) begin
               state_d    = StLaunch;
               cur_hb_d   = sel_hb;
               launch_res = sel_result;
               launch_hb  = sel_hb;
               if (sel_result) gen_data_d = hold_data_q;
            end
         end
         StLaunch: begin
            state_d   = StWaitAck;
            ack_cnt_d = 16'd0;
         end
         StWaitAck: begin
            if (gen_busy) begin
               state_d   = StActive;
               fto_cnt_d = 16'd0;
            end else if (ack_cnt_q == AckLast) begin
               // Request stays pending and is retried at the next blank.
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               ack_cnt_d = ack_cnt_q + 16'd1;
            end
         end
         StActive: begin
            if (!gen_busy) begin
               state_d = StDone;
            end else if (frame_start_q) begin
               if (fto_cnt_q == FtoLast) begin
                  err_d      = 1'b1;
                  clr_served = 1'b1;
                  state_d    = StIdle;
               end else begin
                  fto_cnt_d = fto_cnt_q + 16'd1;
               end
            end
         end
         StDone: begin
            frames_sent_d = frames_sent_q + 16'd1;
            clr_served    = 1'b1;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Served result is always held, so this never collides with a capture.
      if (clr_served && !cur_hb_q) hold_full_d = 1'b0;

      if (hb_set) begin
         hb_pending_d = 1'b1;
      end else if (clr_served && cur_hb_q) begin
         hb_pending_d = 1'b0;
      end

      if (!hb_pending_q || launch_hb) begin
         res_run_d = 16'd0;
      end else if (launch_res) begin
         res_run_d = res_run_q + 16'd1;
      end
   end

   always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         frame_start_q <= 1'b0;
         hold_full_q   <= 1'b0;
         hold_data_q   <= '0;
         hb_pending_q  <= 1'b0;
         hb_cnt_q      <= 16'd0;
         res_run_q     <= 16'd0;
         ack_cnt_q     <= 16'd0;
         fto_cnt_q     <= 16'd0;
         cur_hb_q      <= 1'b0;
         gen_data_q    <= '0;
         frames_sent_q <= 16'd0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_start_q <= frame_start_d;
         hold_full_q   <= hold_full_d;
         hold_data_q   <= hold_data_d;
         hb_pending_q  <= hb_pending_d;
         hb_cnt_q      <= hb_cnt_d;
         res_run_q     <= res_run_d;
         ack_cnt_q     <= ack_cnt_d;
         fto_cnt_q     <= fto_cnt_d;
         cur_hb_q      <= cur_hb_d;
         gen_data_q    <= gen_data_d;
         frames_sent_q <= frames_sent_d;
         err_q         <= err_d;
      end
   end

   assign result_ready       = !hold_full_q;
   assign gen_data           = gen_data_q;
   assign gen_write_enable   = (state_q == StLaunch) && !cur_hb_q;
   assign gen_data_available = (state_q == StLaunch) && cur_hb_q;
   assign frames_sent        = frames_sent_q;
   assign err_timeout        = err_q;

endmodule

// File: tb/tb_pixel_tx_scheduler.sv
// Directed bench for pixel_tx_scheduler: result launch, heartbeat, run limit, timeouts, reset.
module tb_pixel_tx_scheduler;

   localparam int DW = 344;

   logic          tx_pixel_clk;
   logic          rst_n;
   logic [9:0]    x, y;
   logic          result_valid;
   logic [DW-1:0] result_data;
   logic          result_ready;
   logic          gen_busy;
   logic [DW-1:0] gen_data;
   logic          gen_write_enable;
   logic          gen_data_available;
   logic [15:0]   frames_sent;
   logic          err_timeout;

   int checks   = 0;
   int failures = 0;

   pixel_tx_scheduler #(.HB_PERIOD(2)) dut (
      .tx_pixel_clk      (tx_pixel_clk),
      .rst_n             (rst_n),
      .x                 (x),
      .y                 (y),
      .result_valid      (result_valid),
      .result_data       (result_data),
      .result_ready      (result_ready),
      .gen_busy          (gen_busy),
      .gen_data          (gen_data),
      .gen_write_enable  (gen_write_enable),
      .gen_data_available(gen_data_available),
      .frames_sent       (frames_sent),
      .err_timeout       (err_timeout)
   );

   initial tx_pixel_clk = 1'b0;
   always #5 tx_pixel_clk = ~tx_pixel_clk;

   function automatic logic [DW-1:0] pat(input logic [7:0] b);
      pat = {43{b}};
   endfunction

   task automatic tick();
      @(posedge tx_pixel_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_data(input string tag, input logic [DW-1:0] exp);
      checks++;
      assert (gen_data === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, gen_data, exp);
      end
   endtask

   task automatic load(input logic [7:0] b);
      result_valid = 1'b1;
      result_data  = pat(b);
      tick();
      result_valid = 1'b0;
   endtask

   task automatic frame_pulse();
      x = 10'd0;
      y = 10'd0;
      tick();
      x = 10'd10;
      y = 10'd10;
      tick();
   endtask

   // Leaves the bench at the pulse cycle when seen.
   task automatic wait_launch(input bit hb, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (hb ? gen_data_available : gen_write_enable) seen = 1'b1;
      end
   endtask

   task automatic count_pulses(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (gen_write_enable || gen_data_available) cnt++;
      end
   endtask

   task automatic complete();
      gen_busy = 1'b1;
      repeat (3) tick();
      gen_busy = 1'b0;
      repeat (2) tick();
   endtask

   bit seen;
   int cnt;

   initial begin
      rst_n        = 1'b0;
      x            = 10'd10;
      y            = 10'd10;
      result_valid = 1'b0;
      result_data  = '0;
      gen_busy     = 1'b0;
      #12;
      chk("rst_we", 32'(gen_write_enable), 32'd0);
      chk("rst_avail", 32'(gen_data_available), 32'd0);
      chk("rst_frames", 32'(frames_sent), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk("rst_ready", 32'(result_ready), 32'd1);
      chk_data("rst_gen_data", '0);
      rst_n = 1'b1;
      tick();

      // 1) single result
      load(8'h11);
      chk("t1_ready_low", 32'(result_ready), 32'd0);
      count_pulses(5, cnt);
      chk("t1_no_launch_active", 32'(cnt), 32'd0);
      y = 10'd500;
      wait_launch(1'b0, 5, seen);
      chk("t1_we_seen", 32'(seen), 32'd1);
      chk("t1_avail_low", 32'(gen_data_available), 32'd0);
      chk_data("t1_gen_data", pat(8'h11));
      tick();
      chk("t1_we_one_cycle", 32'(gen_write_enable), 32'd0);
      complete();
      chk("t1_frames", 32'(frames_sent), 32'd1);
      chk("t1_ready_back", 32'(result_ready), 32'd1);
      y = 10'd10;

      // 2) heartbeat after two frame starts, only in blanking
      frame_pulse();
      frame_pulse();
      count_pulses(5, cnt);
      chk("t2_no_hb_active", 32'(cnt), 32'd0);
      y = 10'd500;
      wait_launch(1'b1, 5, seen);
      chk("t2_avail_seen", 32'(seen), 32'd1);
      chk("t2_we_low", 32'(gen_write_enable), 32'd0);
      chk_data("t2_gen_data_kept", pat(8'h11));
      y = 10'd10;
      complete();
      chk("t2_frames", 32'(frames_sent), 32'd2);

      // 3) run limit with heartbeat pending
      frame_pulse();
      frame_pulse();
      for (int i = 0; i < 4; i++) begin
         load(8'h30 + 8'(i));
         y = 10'd500;
         wait_launch(1'b0, 5, seen);
         y = 10'd10;
         chk($sformatf("t3_res%0d_seen", i), 32'(seen), 32'd1);
         chk_data($sformatf("t3_res%0d_data", i), pat(8'h30 + 8'(i)));
         complete();
      end
      load(8'h35);
      y = 10'd500;
      wait_launch(1'b1, 5, seen);
      chk("t3_hb_after_run", 32'(seen), 32'd1);
      chk("t3_hb_not_result", 32'(gen_write_enable), 32'd0);
      complete();
      wait_launch(1'b0, 5, seen);
      y = 10'd10;
      chk("t3_resume_seen", 32'(seen), 32'd1);
      chk_data("t3_resume_data", pat(8'h35));
      complete();
      chk("t3_frames", 32'(frames_sent), 32'd8);

      // 4) ack timeout then retry of the same payload
      load(8'h44);
      y = 10'd500;
      wait_launch(1'b0, 5, seen);
      y = 10'd10;
      chk("t4_we_seen", 32'(seen), 32'd1);
      repeat (4) tick();
      chk("t4_err_not_yet", 32'(err_timeout), 32'd0);
      repeat (8) tick();
      chk("t4_err_set", 32'(err_timeout), 32'd1);
      chk("t4_hold_kept", 32'(result_ready), 32'd0);
      y = 10'd500;
      wait_launch(1'b0, 5, seen);
      y = 10'd10;
      chk("t4_retry_seen", 32'(seen), 32'd1);
      chk_data("t4_retry_data", pat(8'h44));
      complete();
      chk("t4_frames", 32'(frames_sent), 32'd9);

      // 6) reset during ACTIVE
      load(8'h66);
      y = 10'd500;
      wait_launch(1'b0, 5, seen);
      chk("t6_we_seen", 32'(seen), 32'd1);
      gen_busy = 1'b1;
      repeat (2) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_we", 32'(gen_write_enable), 32'd0);
      chk("t6_rst_frames", 32'(frames_sent), 32'd0);
      chk("t6_rst_err", 32'(err_timeout), 32'd0);
      chk("t6_rst_ready", 32'(result_ready), 32'd1);
      chk_data("t6_rst_data", '0);
      gen_busy = 1'b0;
      tick();
      rst_n = 1'b1;
      count_pulses(10, cnt);
      chk("t6_no_pulse_after", 32'(cnt), 32'd0);
      y = 10'd10;

      // 5) generator stuck busy across two frame starts
      load(8'h55);
      y = 10'd500;
      wait_launch(1'b0, 5, seen);
      y = 10'd10;
      chk("t5_we_seen", 32'(seen), 32'd1);
      gen_busy = 1'b1;
      repeat (2) tick();
      frame_pulse();
      chk("t5_err_not_yet", 32'(err_timeout), 32'd0);
      frame_pulse();
      chk("t5_err_set", 32'(err_timeout), 32'd1);
      chk("t5_hold_cleared", 32'(result_ready), 32'd1);
      chk("t5_frames_same", 32'(frames_sent), 32'd0);
      // heartbeat now pending but generator still busy
      y = 10'd500;
      count_pulses(5, cnt);
      chk("t5_no_launch_busy", 32'(cnt), 32'd0);
      gen_busy = 1'b0;
      wait_launch(1'b1, 5, seen);
      chk("t5_hb_after_busy", 32'(seen), 32'd1);
      y = 10'd10;
      complete();
      chk("t5_frames_hb", 32'(frames_sent), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
